// File: rtl/alu_share_ctrl_if.sv
// rtl/alu_share_ctrl_if.sv - requester and shared-ALU signal bundle for alu_share_ctrl
interface alu_share_ctrl_if #(
    parameter int DW  = 16,
    parameter int OPW = 3
);
    logic           req0;
    logic           req1;
    logic [DW-1:0]  a0;
    logic [DW-1:0]  b0;
    logic [DW-1:0]  a1;
    logic [DW-1:0]  b1;
    logic           c0;
    logic           c1;
    logic [OPW-1:0] op0;
    logic [OPW-1:0] op1;
    logic           ack0;
    logic           ack1;
    logic           done0;
    logic           done1;
    logic [DW-1:0]  res_w;
    logic           res_zer;
    logic           res_neg;
    logic           res_id;
    logic           res_err;
    logic           busy;
    logic [DW-1:0]  alu_a;
    logic [DW-1:0]  alu_b;
    logic           alu_c;
    logic [OPW-1:0] alu_op;
    logic [DW-1:0]  alu_w;
    logic           alu_zer;
    logic           alu_neg;

    modport slave (
        input  req0, req1, a0, b0, a1, b1, c0, c1, op0, op1,
        input  alu_w, alu_zer, alu_neg,
        output ack0, ack1, done0, done1,
        output res_w, res_zer, res_neg, res_id, res_err, busy,
        output alu_a, alu_b, alu_c, alu_op
    );

    modport master (
        output req0, req1, a0, b0, a1, b1, c0, c1, op0, op1,
        output alu_w, alu_zer, alu_neg,
        input  ack0, ack1, done0, done1,
        input  res_w, res_zer, res_neg, res_id, res_err, busy,
        input  alu_a, alu_b, alu_c, alu_op
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - round-robin controller time-sharing one external ALU between two requesters
module alu_share_ctrl #(
    parameter int DW  = 16,
    parameter int OPW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_share_ctrl_if.slave   bus
);
    typedef enum logic {IDLE, EXEC} state_e;

    state_e         state_q, state_d;
    logic           last_q, last_d;
    logic           gnt_q, gnt_d;
    logic [DW-1:0]  alu_a_q, alu_a_d;
    logic [DW-1:0]  alu_b_q, alu_b_d;
    logic           alu_c_q, alu_c_d;
    logic [OPW-1:0] alu_op_q, alu_op_d;
    logic           ack0_q, ack0_d, ack1_q, ack1_d;
    logic           done0_q, done0_d, done1_q, done1_d;
    logic [DW-1:0]  res_w_q, res_w_d;
    logic           res_zer_q, res_zer_d;
    logic           res_neg_q, res_neg_d;
    logic           res_id_q, res_id_d;
    logic           res_err_q, res_err_d;
    logic           win;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_c_d   = alu_c_q;
        alu_op_d  = alu_op_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        res_w_d   = res_w_q;
        res_zer_d = res_zer_q;
        res_neg_d = res_neg_q;
        res_id_d  = res_id_q;
        res_err_d = res_err_q;
        // Contested requests go to whoever did not win last time.
        win       = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    alu_a_d  = win ? bus.a1  : bus.a0;
                    alu_b_d  = win ? bus.b1  : bus.b0;
                    alu_c_d  = win ? bus.c1  : bus.c0;
                    alu_op_d = win ? bus.op1 : bus.op0;
                    ack0_d   = ~win;
                    ack1_d   = win;
                    last_d   = win;
                    gnt_d    = win;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                res_w_d   = bus.alu_w;
                res_zer_d = bus.alu_zer;
                res_neg_d = bus.alu_neg;
                res_id_d  = gnt_q;
                res_err_d = (alu_op_q == {OPW{1'b1}});
                done0_d   = ~gnt_q;
                done1_d   = gnt_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            gnt_q     <= 1'b0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_c_q   <= 1'b0;
            alu_op_q  <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            res_w_q   <= '0;
            res_zer_q <= 1'b0;
            res_neg_q <= 1'b0;
            res_id_q  <= 1'b0;
            res_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_c_q   <= alu_c_d;
            alu_op_q  <= alu_op_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            res_w_q   <= res_w_d;
            res_zer_q <= res_zer_d;
            res_neg_q <= res_neg_d;
            res_id_q  <= res_id_d;
            res_err_q <= res_err_d;
        end
    end

    assign bus.ack0    = ack0_q;
    assign bus.ack1    = ack1_q;
    assign bus.done0   = done0_q;
    assign bus.done1   = done1_q;
    assign bus.res_w   = res_w_q;
    assign bus.res_zer = res_zer_q;
    assign bus.res_neg = res_neg_q;
    assign bus.res_id  = res_id_q;
    assign bus.res_err = res_err_q;
    assign bus.busy    = (state_q == EXEC);
    assign bus.alu_a   = alu_a_q;
    assign bus.alu_b   = alu_b_q;
    assign bus.alu_c   = alu_c_q;
    assign bus.alu_op  = alu_op_q;
endmodule
